// File: rtl/video_mixer.sv
// Pixel mixer: sprite-over-tile priority select, palette bank latch, palette ROM lookup and
// registered RGB 3-3-2 output with blank/sync delayed to match the ROM latency.
module video_mixer #(
    parameter int unsigned PIX_PHASE  = 0,
    parameter int unsigned CAP_PHASE  = 2,
    parameter bit          PAL_INVERT = 1'b1,
    parameter bit          BANK_SYNC  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] phi,
    input  logic [1:0] tile_vid,
    input  logic [3:0] tile_col,
    input  logic [1:0] obj_vid,
    input  logic [3:0] obj_col,
    input  logic       cmpblk2,
    input  logic       vblk,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       bank_wr,
    input  logic       bank_sel,
    input  logic       bank_din,
    output logic [7:0] pal_addr,
    input  logic [7:0] pal_data,
    output logic [2:0] rgb_r,
    output logic [2:0] rgb_g,
    output logic [1:0] rgb_b,
    output logic       hsync,
    output logic       vsync,
    output logic       blank
);

    logic       strobe_a;
    logic       strobe_b;
    logic [1:0] pending_bank;
    logic [1:0] pending_next;
    logic [1:0] active_bank;
    logic       vblk_d;
    logic       vblk_rise;
    logic [5:0] sel;
    logic [7:0] pal_d;
    logic [7:0] mix_addr;
    logic       blank_a;
    logic       hs_a;
    logic       vs_a;

    assign strobe_a = (phi == 3'(PIX_PHASE));
    assign strobe_b = (phi == 3'(CAP_PHASE));
    assign pal_addr = mix_addr;

    always_comb begin
        pending_next = pending_bank;
        if (bank_wr) begin
            pending_next[bank_sel] = bank_din;
        end
        vblk_rise = vblk & ~vblk_d;
        // A non-transparent sprite always covers the tile layer.
        sel   = (obj_vid != 2'd0) ? {obj_col, obj_vid} : {tile_col, tile_vid};
        pal_d = PAL_INVERT ? ~pal_data : pal_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_bank <= 2'd0;
            active_bank  <= 2'd0;
            vblk_d       <= 1'b0;
            mix_addr     <= 8'd0;
            // Stage A resets to a blanked pixel so no stale colour leaks out after reset.
            blank_a      <= 1'b1;
            hs_a         <= 1'b1;
            vs_a         <= 1'b1;
            rgb_r        <= 3'd0;
            rgb_g        <= 3'd0;
            rgb_b        <= 2'd0;
            blank        <= 1'b1;
            hsync        <= 1'b1;
            vsync        <= 1'b1;
        end else begin
            pending_bank <= pending_next;
            vblk_d       <= vblk;
            if (BANK_SYNC) begin
                if (vblk_rise) begin
                    active_bank <= pending_next;
                end
            end else begin
                active_bank <= pending_next;
            end

            if (strobe_a) begin
                mix_addr <= {active_bank, sel};
                blank_a  <= cmpblk2;
                hs_a     <= hsync_in;
                vs_a     <= vsync_in;
            end

            if (strobe_b) begin
                if (blank_a) begin
                    rgb_r <= 3'd0;
                    rgb_g <= 3'd0;
                    rgb_b <= 2'd0;
                end else begin
                    rgb_r <= pal_d[7:5];
                    rgb_g <= pal_d[4:2];
                    rgb_b <= pal_d[1:0];
                end
                blank <= blank_a;
                hsync <= hs_a;
                vsync <= vs_a;
            end
        end
    end

endmodule

// File: tb/tb_video_mixer.sv
// Bench for video_mixer: two instances (vblank-synchronised and immediate bank update) sharing
// stimulus, each with its own palette ROM, checked against a per-pixel reference model.
module tb_video_mixer;

    typedef struct packed {
        logic       blank;
        logic       hs;
        logic       vs;
        logic [7:0] a;
    } pix_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] phi;
    logic [1:0] tile_vid;
    logic [3:0] tile_col;
    logic [1:0] obj_vid;
    logic [3:0] obj_col;
    logic       cmpblk2;
    logic       vblk;
    logic       hsync_in;
    logic       vsync_in;
    logic       bank_wr;
    logic       bank_sel;
    logic       bank_din;

    logic [7:0] pal_addr0, pal_addr1;
    logic [7:0] pal_data0, pal_data1;
    logic [2:0] rgb_r0, rgb_r1, rgb_g0, rgb_g1;
    logic [1:0] rgb_b0, rgb_b1;
    logic       hsync0, hsync1, vsync0, vsync1, blank0, blank1;

    logic [7:0] rom [256];

    int n_cmp = 0;
    int n_bad = 0;
    int ph    = 0;

    // Reference model state
    logic [1:0]  m_pend, m_act0, m_act1;
    logic        m_vprev;
    logic [7:0]  e_addr0, e_addr1;
    pix_t        p0, p1;
    logic [10:0] e_out0, e_out1;

    localparam logic [10:0] OutReset = {8'h00, 1'b1, 1'b1, 1'b1};
    localparam pix_t        PixIdle  = '{blank: 1'b1, hs: 1'b1, vs: 1'b1, a: 8'h00};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        pal_data0 <= rom[pal_addr0];
        pal_data1 <= rom[pal_addr1];
    end

    video_mixer #(.PIX_PHASE(0), .CAP_PHASE(2), .PAL_INVERT(1'b1), .BANK_SYNC(1'b1)) dut0 (
        .clk(clk), .rst(rst), .phi(phi), .tile_vid(tile_vid), .tile_col(tile_col),
        .obj_vid(obj_vid), .obj_col(obj_col), .cmpblk2(cmpblk2), .vblk(vblk),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .bank_wr(bank_wr), .bank_sel(bank_sel),
        .bank_din(bank_din), .pal_addr(pal_addr0), .pal_data(pal_data0), .rgb_r(rgb_r0),
        .rgb_g(rgb_g0), .rgb_b(rgb_b0), .hsync(hsync0), .vsync(vsync0), .blank(blank0)
    );

    video_mixer #(.PIX_PHASE(0), .CAP_PHASE(2), .PAL_INVERT(1'b1), .BANK_SYNC(1'b0)) dut1 (
        .clk(clk), .rst(rst), .phi(phi), .tile_vid(tile_vid), .tile_col(tile_col),
        .obj_vid(obj_vid), .obj_col(obj_col), .cmpblk2(cmpblk2), .vblk(vblk),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .bank_wr(bank_wr), .bank_sel(bank_sel),
        .bank_din(bank_din), .pal_addr(pal_addr1), .pal_data(pal_data1), .rgb_r(rgb_r1),
        .rgb_g(rgb_g1), .rgb_b(rgb_b1), .hsync(hsync1), .vsync(vsync1), .blank(blank1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected output word {rgb(8), blank, hsync, vsync} for a pixel; ROM data is active-low.
    function automatic logic [10:0] render(input pix_t p);
        logic [7:0] d;
        d = p.blank ? 8'h00 : ~rom[p.a];
        return {d, p.blank, p.hs, p.vs};
    endfunction

    function automatic logic [10:0] out0();
        return {rgb_r0, rgb_g0, rgb_b0, blank0, hsync0, vsync0};
    endfunction

    function automatic logic [10:0] out1();
        return {rgb_r1, rgb_g1, rgb_b1, blank1, hsync1, vsync1};
    endfunction

    // One clock: present phi, advance the model, then compare just after the edge.
    task automatic step();
        logic [5:0] s;
        logic [1:0] np;
        phi = 3'(ph);
        if (rst) begin
            m_pend  = 2'd0;
            m_act0  = 2'd0;
            m_act1  = 2'd0;
            m_vprev = 1'b0;
            e_addr0 = 8'h00;
            e_addr1 = 8'h00;
            p0      = PixIdle;
            p1      = PixIdle;
            e_out0  = OutReset;
            e_out1  = OutReset;
        end else begin
            if (ph == 0) begin
                s       = (obj_vid != 2'd0) ? {obj_col, obj_vid} : {tile_col, tile_vid};
                e_addr0 = {m_act0, s};
                e_addr1 = {m_act1, s};
                p0      = '{blank: cmpblk2, hs: hsync_in, vs: vsync_in, a: e_addr0};
                p1      = '{blank: cmpblk2, hs: hsync_in, vs: vsync_in, a: e_addr1};
            end
            if (ph == 2) begin
                e_out0 = render(p0);
                e_out1 = render(p1);
            end
            np = m_pend;
            if (bank_wr) np[bank_sel] = bank_din;
            if (vblk && !m_vprev) m_act0 = np;
            m_act1  = np;
            m_pend  = np;
            m_vprev = vblk;
        end
        @(posedge clk);
        #1;
        check("addr_sync", 32'(pal_addr0), 32'(e_addr0));
        check("addr_imm", 32'(pal_addr1), 32'(e_addr1));
        check("out_sync", 32'(out0()), 32'(e_out0));
        check("out_imm", 32'(out1()), 32'(e_out1));
        ph = (ph + 1) % 8;
    endtask

    task automatic align(input int target);
        while (ph != target) step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        rom[8'h16] = 8'h00;
        rom[8'h29] = 8'hFF;
        rom[8'h0D] = 8'h5A;

        rst = 1'b1;  phi = 3'd0;
        tile_vid = 2'd0; tile_col = 4'd0; obj_vid = 2'd0; obj_col = 4'd0;
        cmpblk2 = 1'b0; vblk = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        bank_wr = 1'b0; bank_sel = 1'b0; bank_din = 1'b0;
        repeat (3) step();
        check("reset_out", 32'(out0()), 32'(OutReset));
        check("reset_addr", 32'(pal_addr0), 32'h0);
        rst = 1'b0;

        // Tile pixel, then sprite pixel over it
        align(0);
        tile_vid = 2'd2; tile_col = 4'd5; obj_vid = 2'd0; obj_col = 4'd0;
        step();
        check("prio_tile", 32'(pal_addr0), 32'h16);
        step(); step();
        check("pal_zero", 32'(out0()), 32'({8'hFF, 1'b0, 1'b1, 1'b1}));
        align(0);
        obj_vid = 2'd1; obj_col = 4'hA;
        step();
        check("prio_obj", 32'(pal_addr0), 32'h29);
        step(); step();
        check("pal_ones", 32'(out0()), 32'({8'h00, 1'b0, 1'b1, 1'b1}));

        // Blanked pixel with hsync asserted
        align(0);
        tile_vid = 2'd1; tile_col = 4'd3; obj_vid = 2'd0; cmpblk2 = 1'b1; hsync_in = 1'b0;
        step();
        check("blank_addr", 32'(pal_addr0), 32'h0D);
        step();
        check("blank_lat", 32'(blank0), 32'd0);
        step();
        check("blank_out", 32'(out0()), 32'({8'h00, 1'b1, 1'b0, 1'b1}));
        cmpblk2 = 1'b0; hsync_in = 1'b1;

        // Bank write mid-frame: held until vblank on dut0, immediate on dut1
        align(3);
        bank_wr = 1'b1; bank_sel = 1'b1; bank_din = 1'b1;
        step();
        bank_wr = 1'b0;
        align(0);
        step();
        check("bank_hold", 32'(pal_addr0[7:6]), 32'd0);
        check("bank_imm", 32'(pal_addr1[7:6]), 32'd2);
        vblk = 1'b1;
        step();
        align(0);
        step();
        check("bank_vblk", 32'(pal_addr0[7:6]), 32'd2);
        vblk = 1'b0;
        step(); step();
        bank_wr = 1'b1; bank_sel = 1'b0; bank_din = 1'b1; vblk = 1'b1;
        step();
        bank_wr = 1'b0;
        align(0);
        step();
        check("bank_coinc", 32'(pal_addr0[7:6]), 32'd3);
        vblk = 1'b0;

        // Single-clock reset during active video
        align(1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_out", 32'(out0()), 32'(OutReset));
        check("midrst_addr", 32'(pal_addr0), 32'h0);

        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 599) == 0);
            bank_wr  = ($urandom_range(0, 15) == 0);
            bank_sel = 1'($urandom);
            bank_din = 1'($urandom);
            if ($urandom_range(0, 39) == 0) vblk = ~vblk;
            tile_vid = 2'($urandom);
            tile_col = 4'($urandom);
            obj_vid  = $urandom_range(0, 1) ? 2'd0 : 2'($urandom);
            obj_col  = 4'($urandom);
            cmpblk2  = ($urandom_range(0, 7) == 0);
            hsync_in = ($urandom_range(0, 9) != 0);
            vsync_in = ($urandom_range(0, 19) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
